// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: one-outstanding-request memory front end
// feeding a small FIFO of {instruction, pc} pairs, with redirect/flush support.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_code,
  output logic [31:0] inst_pc
);

  localparam int PW = (BUF_DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   code_mem [BUF_DEPTH];
  logic [31:0]   pc_mem   [BUF_DEPTH];

  logic          req_want;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic [31:0]   redirect_target;

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // Next-state and request/push decode; a redirect overrides everything in its cycle.
  always_comb begin
    state_nxt = state;
    req_want  = 1'b0;
    push      = 1'b0;
    unique case (state)
      S_REQ: begin
        req_want = (count < DEPTH_C) && !redirect_valid;
        if (req_want && imem_req_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          state_nxt = imem_rsp_valid ? S_REQ : S_DRAIN;
        end else if (imem_rsp_valid) begin
          push      = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_rsp_valid) begin
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  // rst_n gates the request so nothing is issued while reset is held.
  assign imem_req_valid = req_want & rst_n;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign inst_valid = (count != '0) && !redirect_valid;
  assign inst_code  = code_mem[head];
  assign inst_pc    = pc_mem[head];
  assign pop        = inst_valid & inst_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      req_pc <= 32'h0000_0000;
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        pc <= redirect_target;
      end else if (req_fire) begin
        pc <= pc + 32'd4;
      end
      if (req_fire) begin
        req_pc <= pc;
      end
    end
  end

  // Buffer pointers and occupancy; a redirect flushes to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        code_mem[i] <= 32'h0000_0000;
        pc_mem[i]   <= 32'h0000_0000;
      end
    end else if (push) begin
      code_mem[tail] <= imem_rsp_data;
      pc_mem[tail]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed scoreboard bench for instr_fetch
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_ready;

  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        inst_valid;
  logic [31:0] inst_code;
  logic [31:0] inst_pc;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_inst_valid;
  logic [31:0] w_inst_code;
  logic [31:0] w_inst_pc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] code;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          mem_lat  = 1;
  logic        fire;
  logic [31:0] fire_addr;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_code(inst_code), .inst_pc(inst_pc)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(w_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(w_inst_valid), .inst_ready(inst_ready),
    .inst_code(w_inst_code), .inst_pc(w_inst_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'h0013} ^ {16'hC3A5, a[31:16]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_inst(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.code = mem_word(pc);
    exp_q.push_back(e);
  endtask

  task automatic wait_empty(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check(tag, exp_q.size(), 0);
  endtask

  // Memory model: one response per accepted request, mem_lat cycles later.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(posedge clk);
      fire      = rst_n && imem_req_valid && imem_req_ready;
      fire_addr = imem_req_addr;
      #1 imem_rsp_valid = 1'b0;
      if (fire) begin
        repeat (mem_lat - 1) begin
          @(posedge clk);
          #1;
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(fire_addr);
      end
    end
  end

  // Scoreboard: every accepted instruction must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready) begin
      check("sb_pop_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_inst_pc", inst_pc, e.pc);
        check("sb_inst_code", inst_code, e.code);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    repeat (3) tick();
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst_code", inst_code, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_wrap_req_valid", w_req_valid, 0);
    check("rst_wrap_inst", {w_inst_valid, w_inst_code[30:0] | w_inst_pc[30:0]}, 0);

    // Streaming at full rate, plus the wrap-around instance.
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    mem_lat        = 1;
    expect_inst(32'h0);
    expect_inst(32'h4);
    expect_inst(32'h8);
    tick(); rst_n = 1'b1; #1;
    check("c0_req_valid", imem_req_valid, 1);
    check("c0_req_addr", imem_req_addr, 32'h0);
    check("c0_wrap_req_valid", w_req_valid, 1);
    check("c0_wrap_req_addr", w_req_addr, 32'hFFFF_FFFC);
    tick(); #1;
    check("c1_req_valid", imem_req_valid, 0);
    check("c1_inst_valid", inst_valid, 0);
    tick(); #1;
    check("c2_inst_valid", inst_valid, 1);
    check("c2_req_addr", imem_req_addr, 32'h4);
    check("c2_wrap_req_valid", w_req_valid, 1);
    check("c2_wrap_req_addr", w_req_addr, 32'h0);
    tick(); #1;
    check("c3_inst_valid", inst_valid, 0);
    tick(); #1;
    check("c4_inst_valid", inst_valid, 1);
    check("c4_inst_pc", inst_pc, 32'h4);
    tick(); tick(); tick();
    inst_ready = 1'b0;
    wait_empty("stream_drained", 4);

    // Back-pressure fills the buffer and stalls requests.
    rst_n = 1'b0;
    tick(); tick(); #1;
    check("rst2_inst_valid", inst_valid, 0);
    check("rst2_inst_code", inst_code, 0);
    check("rst2_req_addr", imem_req_addr, 32'h0);
    expect_inst(32'h0);
    expect_inst(32'h4);
    expect_inst(32'h8);
    tick(); rst_n = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 6; i++) begin
      #1;
      check("full_no_req", imem_req_valid, 0);
      tick();
    end
    check("full_inst_valid", inst_valid, 1);
    check("full_head_pc", inst_pc, 32'h0);
    check("full_head_code", inst_code, mem_word(32'h0));
    inst_ready = 1'b1;
    tick(); #1;
    check("resume_req_valid", imem_req_valid, 1);
    check("resume_req_addr", imem_req_addr, 32'h8);
    wait_empty("bp_drained", 12);
    inst_ready = 1'b0;

    // Redirect in WAIT, stale response two cycles after the request.
    rst_n = 1'b0;
    tick();
    mem_lat    = 2;
    inst_ready = 1'b1;
    tick(); rst_n = 1'b1; #1;
    check("r1_c0_req_addr", imem_req_addr, 32'h0);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    check("r1_redir_inst_valid", inst_valid, 0);
    check("r1_redir_req_valid", imem_req_valid, 0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("r1_drain_req_valid", imem_req_valid, 0);
    tick(); #1;
    check("r1_refetch_valid", imem_req_valid, 1);
    check("r1_refetch_addr", imem_req_addr, 32'h0000_0100);
    expect_inst(32'h0000_0100);
    wait_empty("r1_drained", 10);
    inst_ready = 1'b0;

    // Two redirects before the stale response; only the last one counts.
    rst_n = 1'b0;
    tick();
    mem_lat    = 3;
    inst_ready = 1'b1;
    tick(); rst_n = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    #1;
    check("r2_wait_req_valid", imem_req_valid, 0);
    tick();
    redirect_pc = 32'h0000_0306;
    #1;
    check("r2_drain_redir_req_valid", imem_req_valid, 0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("r2_drain_rsp_req_valid", imem_req_valid, 0);
    tick(); #1;
    check("r2_refetch_valid", imem_req_valid, 1);
    check("r2_refetch_addr", imem_req_addr, 32'h0000_0304);
    expect_inst(32'h0000_0304);
    wait_empty("r2_drained", 12);
    inst_ready = 1'b0;

    // Redirect coincident with a response and a pending pop.
    rst_n = 1'b0;
    tick();
    mem_lat = 1;
    tick(); rst_n = 1'b1;
    tick(); tick(); #1;
    check("r3_buf_inst_valid", inst_valid, 1);
    check("r3_buf_req_addr", imem_req_addr, 32'h4);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    inst_ready     = 1'b1;
    #1;
    check("r3_redir_inst_valid", inst_valid, 0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("r3_flushed", inst_valid, 0);
    check("r3_req_valid", imem_req_valid, 1);
    check("r3_req_addr", imem_req_addr, 32'h0000_0040);
    expect_inst(32'h0000_0040);
    wait_empty("r3_drained", 8);
    inst_ready = 1'b0;

    // Reset pulse while a request is outstanding; its response lands after release.
    rst_n = 1'b0;
    tick();
    mem_lat    = 2;
    inst_ready = 1'b1;
    tick(); rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    check("r4_rst_req_valid", imem_req_valid, 0);
    check("r4_rst_inst_valid", inst_valid, 0);
    check("r4_rst_inst_pc", inst_pc, 0);
    check("r4_rst_req_addr", imem_req_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    check("r4_rel_req_valid", imem_req_valid, 1);
    check("r4_rel_req_addr", imem_req_addr, 32'h0);
    tick(); #1;
    check("r4_late_rsp_dropped", inst_valid, 0);
    check("r4_wait_req_valid", imem_req_valid, 0);
    expect_inst(32'h0);
    wait_empty("r4_drained", 8);
    inst_ready = 1'b0;

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
